round_sat_pipe: RTL and testbench
=================================

// Module: round_sat_pipe
// PURPOSE
//  Pipelined, mode-selectable fixed-point rounder with saturation for valid/ready streams.
//  Clears the NBITS LSBs of each sample using the per-sample rounding mode.
//  Clamps the result on overflow instead of wrapping, and counts saturation events.
//  Sits in the datapath wherever fractional bits are dropped, for example after multiply/accumulate.
// PARAMETERS
//  DIN     16  sample width in bits
//  NBITS   4   LSBs rounded away, 0..DIN-1; 0 gives a pass-through with a 2-cycle delay
//  SIGNED  0   1 = two's-complement samples, 0 = unsigned
//  SATW    16  width of the saturation event counter
// PORTS
//  clk         in   1      clock
//  rst         in   1      asynchronous reset, active-high
//  din_data    in   DIN    input sample
//  din_mode    in   2      rounding mode, sampled with din_data: 0 TRUNC, 1 HALF_UP, 2 HALF_EVEN, 3 = TRUNC
//  din_valid   in   1      input sample valid
//  din_ready   out  1      block can accept a sample
//  dout_data   out  DIN    rounded sample; low NBITS bits are always 0
//  dout_sat    out  1      this sample was saturated
//  dout_valid  out  1      output sample valid
//  dout_ready  in   1      downstream accepts the sample
//  sat_clr     in   1      synchronous clear of sat_cnt
//  sat_cnt     out  SATW   saturation event count, sticks at all-ones
// BEHAVIOUR
//  - Reset (async, any cycle): all valid flags 0, dout_data 0, dout_sat 0, sat_cnt 0.
//    In-flight samples are discarded. No output activity until the first edge after rst deasserts.
//  - Handshake: transfer occurs when valid && ready in the same cycle.
//    - dout_valid never depends combinationally on din_valid.
//    - Once asserted, dout_valid/dout_data/dout_sat are held stable until dout_ready.
//  - Pipeline has 2 register stages. Each stage has ready_k = !valid_k || ready_{k+1}, so din_ready = ready_1.
//  - Latency is exactly 2 cycles with no stall. Throughput is 1 sample/cycle.
//    Holds at most 2 samples under backpressure. No loss, no reordering.
//  - Stage 1 (add): computes sum = ext(din) + inc, with ext = 1-bit sign/zero extension to DIN+1 bits.
//    - TRUNC: inc = 0.
//    - HALF_UP: inc = 1<<(NBITS-1).
//    - HALF_EVEN: inc = (1<<(NBITS-1)) - 1 + din[NBITS].
//    - NBITS = 0: inc = 0 for every mode.
//    - Registers sum and the input sign.
//  - Stage 2 (clamp):
//    - Unsigned: overflow when sum[DIN] = 1.
//    - Signed: overflow when the input sign is 0 and sum[DIN-1] = 1. Negative inputs cannot overflow.
//    - On overflow: result = largest representable value with low NBITS = 0, i.e. 0xFFF0 unsigned or 0x7FF0 signed (DIN=16, NBITS=4). dout_sat = 1.
//    - Otherwise: result = {sum[DIN-1:NBITS], NBITS'b0}, dout_sat = 0.
//  - sat_cnt increments once per *transferred* output (dout_valid && dout_ready && dout_sat).
//    - Saturates at 2^SATW - 1.
//    - If sat_clr and an increment occur in the same cycle, the clear wins and the count is 0.
//  - din_mode travels with its sample. Mode changes between consecutive samples take effect per sample.
// STRUCTURE
//  - Package round_pkg: mode constants RND_TRUNC=2'd0, RND_HALF_UP=2'd1, RND_HALF_EVEN=2'd2, and typedef rnd_mode_t.
//  - Sub-module round_pipe_stage #(W): one valid/ready register slice, instantiated twice.
//    Stage 1 payload: sum plus sign. Stage 2 payload: data plus sat.
//  - Top level holds the add logic, clamp logic and the sat_cnt counter.
// TESTING  (DIN=16, NBITS=4 unless noted; dout_ready=1 unless noted)
//  1. Unsigned HALF_UP: 0x0018 -> 0x0020 and 0x0017 -> 0x0010, each appearing 2 cycles after accept.
//     TRUNC: 0x001F -> 0x0010.
//  2. Unsigned HALF_EVEN: 0x0008 -> 0x0000, 0x0018 -> 0x0020, 0x0028 -> 0x0020.
//     Back-to-back samples with mixed modes give correct per-sample results.
//  3. SIGNED=1: 0xFFE8 gives HALF_UP 0xFFF0 and HALF_EVEN 0xFFE0.
//     0x7FF8 with HALF_UP gives 0x7FF0, dout_sat=1 and sat_cnt=1.
//  4. SIGNED=0: 0xFFF8 with HALF_UP gives 0xFFF0 and dout_sat=1.
//     Hold dout_ready=0 for 3 cycles: sat_cnt does not advance until the transfer.
//     Pulse sat_clr in the same cycle as a saturated transfer: sat_cnt reads 0.
//  5. Backpressure: stream 0x10,0x20,0x30,0x40 with dout_ready=0 for 5 cycles.
//     din_ready drops after 2 accepts and dout_data stays stable.
//     After release, all 4 samples come out in order with no duplicates.
//  6. Assert rst mid-stream while 2 samples are in flight.
//     dout_valid goes to 0 immediately, without waiting for a clock edge, and sat_cnt goes to 0.
//     The first sample sent after reset emerges 2 cycles after it is accepted.
//     Also run NBITS=0: every sample passes through unchanged.

Source files
------------

// File: rtl/round_pkg.sv
// Shared rounding-mode definitions for the round/saturate pipeline.
package round_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'd0,
        RND_HALF_UP   = 2'd1,
        RND_HALF_EVEN = 2'd2,
        RND_TRUNC_ALT = 2'd3
    } rnd_mode_t;

endpackage

// File: rtl/round_sat_pipe_if.sv
// Sample stream in/out of the rounder. The master is the producer of din_* and the consumer of dout_*.
// A sample moves across a side in any cycle where its valid and ready are both high at the clock edge.
interface round_sat_pipe_if #(parameter int DIN = 16);

    logic [DIN-1:0] din_data;
    logic [1:0]     din_mode;
    logic           din_valid;
    logic           din_ready;
    logic [DIN-1:0] dout_data;
    logic           dout_sat;
    logic           dout_valid;
    logic           dout_ready;

    modport master (
        output din_data, din_mode, din_valid, dout_ready,
        input  din_ready, dout_data, dout_sat, dout_valid
    );

    modport slave (
        input  din_data, din_mode, din_valid, dout_ready,
        output din_ready, dout_data, dout_sat, dout_valid
    );

endinterface

// File: rtl/round_pipe_stage.sv
// One valid/ready register slice; accepts new data whenever empty or draining downstream.
module round_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/round_sat_pipe.sv
// Two-stage rounder: stage 1 adds the per-mode rounding increment, stage 2 clamps and drops the low NBITS.
// Also counts saturated samples that are actually handed downstream.
module round_sat_pipe
    import round_pkg::*;
#(
    parameter int DIN    = 16,
    parameter int NBITS  = 4,
    parameter bit SIGNED = 1'b0,
    parameter int SATW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    round_sat_pipe_if.slave bus,
    input  logic            sat_clr,
    output logic [SATW-1:0] sat_cnt
);

    localparam int             NBH  = (NBITS > 0) ? NBITS - 1 : 0;
    localparam logic [DIN:0]   ONE  = {{DIN{1'b0}}, 1'b1};
    localparam logic [DIN:0]   HALF = (NBITS > 0) ? (ONE << NBH) : '0;
    localparam logic [DIN-1:0] KEEP = {DIN{1'b1}} << NBITS;
    localparam logic [DIN-1:0] MAXV = (SIGNED ? {1'b0, {(DIN-1){1'b1}}} : {DIN{1'b1}}) & KEEP;

    rnd_mode_t       w_mode;
    logic            w_sign;
    logic [DIN:0]    w_ext;
    logic [DIN:0]    w_inc;
    logic [DIN:0]    w_sum;
    logic            w_s1_valid;
    logic            w_s1_ready;
    logic [DIN+1:0]  w_s1_data;
    logic            w_s1_sign;
    logic [DIN:0]    w_s1_sum;
    logic            w_ovf;
    logic [DIN-1:0]  w_res;
    logic [DIN:0]    w_s2_data;
    logic            w_sat_evt;
    logic [SATW-1:0] r_sat_cnt;

    assign w_mode = rnd_mode_t'(bus.din_mode);
    assign w_sign = SIGNED ? bus.din_data[DIN-1] : 1'b0;
    assign w_ext  = {w_sign, bus.din_data};

    // HALF_EVEN adds just under one half, plus the kept LSB, so exact ties go to the even neighbour.
    always_comb begin
        w_inc = '0;
        if (NBITS > 0) begin
            case (w_mode)
                RND_HALF_UP:   w_inc = HALF;
                RND_HALF_EVEN: w_inc = HALF - ONE + {{DIN{1'b0}}, bus.din_data[NBITS]};
                default:       w_inc = '0;
            endcase
        end
    end

    assign w_sum = w_ext + w_inc;

    round_pipe_stage #(.W(DIN + 2)) u_stage_add (
        .clk     (clk),
        .rst     (rst),
        .i_valid (bus.din_valid),
        .o_ready (bus.din_ready),
        .i_data  ({w_sign, w_sum}),
        .o_valid (w_s1_valid),
        .i_ready (w_s1_ready),
        .o_data  (w_s1_data)
    );

    assign {w_s1_sign, w_s1_sum} = w_s1_data;

    // A negative input can only move towards zero, so only non-negative signed inputs can overflow.
    assign w_ovf = SIGNED ? (!w_s1_sign && w_s1_sum[DIN-1]) : w_s1_sum[DIN];
    assign w_res = w_ovf ? MAXV : (w_s1_sum[DIN-1:0] & KEEP);

    round_pipe_stage #(.W(DIN + 1)) u_stage_clamp (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_s1_valid),
        .o_ready (w_s1_ready),
        .i_data  ({w_ovf, w_res}),
        .o_valid (bus.dout_valid),
        .i_ready (bus.dout_ready),
        .o_data  (w_s2_data)
    );

    assign bus.dout_sat  = w_s2_data[DIN];
    assign bus.dout_data = w_s2_data[DIN-1:0];

    assign w_sat_evt = bus.dout_valid && bus.dout_ready && bus.dout_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (w_sat_evt && (r_sat_cnt != {SATW{1'b1}})) begin
            r_sat_cnt <= r_sat_cnt + SATW'(1);
        end
    end

    assign sat_cnt = r_sat_cnt;

endmodule

// File: tb/tb_round_sat_pipe.sv
// Bench for round_sat_pipe: unsigned/NBITS=4, signed/NBITS=4 (2-bit counter) and unsigned/NBITS=0 instances.
`timescale 1ns/1ps
module tb_round_sat_pipe;

    localparam int DIN = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    round_sat_pipe_if #(.DIN(DIN)) bus_u ();
    round_sat_pipe_if #(.DIN(DIN)) bus_s ();
    round_sat_pipe_if #(.DIN(DIN)) bus_z ();

    logic        clr_u = 1'b0;
    logic        clr_s = 1'b0;
    logic        clr_z = 1'b0;
    logic [15:0] cnt_u;
    logic [1:0]  cnt_s;
    logic [15:0] cnt_z;

    round_sat_pipe #(.DIN(DIN), .NBITS(4), .SIGNED(1'b0), .SATW(16)) dut_u (
        .clk(clk), .rst(rst), .bus(bus_u.slave), .sat_clr(clr_u), .sat_cnt(cnt_u));
    round_sat_pipe #(.DIN(DIN), .NBITS(4), .SIGNED(1'b1), .SATW(2)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s.slave), .sat_clr(clr_s), .sat_cnt(cnt_s));
    round_sat_pipe #(.DIN(DIN), .NBITS(0), .SIGNED(1'b0), .SATW(16)) dut_z (
        .clk(clk), .rst(rst), .bus(bus_z.slave), .sat_clr(clr_z), .sat_cnt(cnt_z));

    int errors = 0;
    int checks = 0;
    logic [16:0] exp_q[$];

    // Reference: round the integer value to a multiple of 2^nb, then clamp to the largest such multiple.
    function automatic void ref_round(input logic [15:0] d, input logic [1:0] m, input bit sgn,
                                      input int nb, output logic [15:0] q_out, output logic q_sat);
        longint v, q, r, base, res, maxv;
        v    = sgn ? longint'($signed(d)) : longint'({48'd0, d});
        q    = longint'(1) << nb;
        r    = ((v % q) + q) % q;
        base = v - r;
        res  = base;
        if (m == 2'd1 && nb > 0 && r >= q / 2) res = base + q;
        if (m == 2'd2 && nb > 0 && (r > q / 2 || (r == q / 2 && ((base / q) % 2) != 0))) res = base + q;
        maxv  = (sgn ? (longint'(1) << 15) : (longint'(1) << 16)) - q;
        q_sat = (res > maxv);
        q_out = q_sat ? maxv[15:0] : res[15:0];
    endfunction

    task automatic test_reset();
        bus_u.din_valid = 1'b0; bus_u.din_data = '0; bus_u.din_mode = 2'd0; bus_u.dout_ready = 1'b1;
        bus_s.din_valid = 1'b0; bus_s.din_data = '0; bus_s.din_mode = 2'd0; bus_s.dout_ready = 1'b1;
        bus_z.din_valid = 1'b0; bus_z.din_data = '0; bus_z.din_mode = 2'd0; bus_z.dout_ready = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++; if (bus_u.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus_u.dout_valid); end
        checks++; if (bus_u.dout_data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", bus_u.dout_data); end
        checks++; if (bus_u.dout_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got=%b exp=0", bus_u.dout_sat); end
        checks++; if (cnt_u !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0000", cnt_u); end
        checks++; if (bus_u.din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus_u.din_ready); end
        checks++; if (bus_s.dout_valid !== 1'b0 || cnt_s !== 2'd0) begin
            errors++; $display("FAIL reset_signed got valid=%b cnt=%0d exp 0/0", bus_s.dout_valid, cnt_s);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus_u.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_idle got=%b exp=0", bus_u.dout_valid); end
    endtask

    task automatic test_unsigned_round();
        logic [15:0] vd [5];
        logic [1:0]  vm [5];
        logic [15:0] ve [5];
        vd = '{16'h0018, 16'h0017, 16'h001F, 16'h001F, 16'h0008};
        vm = '{2'd1, 2'd1, 2'd0, 2'd3, 2'd2};
        ve = '{16'h0020, 16'h0010, 16'h0010, 16'h0010, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus_u.din_data = vd[i]; bus_u.din_mode = vm[i]; bus_u.din_valid = 1'b1;
            #2;
            checks++; if (bus_u.din_ready !== 1'b1) begin errors++; $display("FAIL round_ready[%0d] got=%b exp=1", i, bus_u.din_ready); end
            @(negedge clk);
            bus_u.din_valid = 1'b0;
            checks++; if (bus_u.dout_valid !== 1'b0) begin errors++; $display("FAIL round_early[%0d] got valid=%b exp=0", i, bus_u.dout_valid); end
            @(negedge clk);
            checks++;
            if (bus_u.dout_valid !== 1'b1 || bus_u.dout_data !== ve[i] || bus_u.dout_sat !== 1'b0) begin
                errors++;
                $display("FAIL round[%0d] in=%h mode=%0d got valid=%b data=%h sat=%b exp valid=1 data=%h sat=0",
                         i, vd[i], vm[i], bus_u.dout_valid, bus_u.dout_data, bus_u.dout_sat, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vd [4];
        logic [1:0]  vm [4];
        logic [15:0] ve [4];
        vd = '{16'h0008, 16'h0018, 16'h0028, 16'h001F};
        vm = '{2'd2, 2'd1, 2'd2, 2'd0};
        ve = '{16'h0000, 16'h0020, 16'h0020, 16'h0010};
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (t >= 2) begin
                checks++;
                if (bus_u.dout_valid !== 1'b1 || bus_u.dout_data !== ve[t-2] || bus_u.dout_sat !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b[%0d] got valid=%b data=%h sat=%b exp valid=1 data=%h sat=0",
                             t - 2, bus_u.dout_valid, bus_u.dout_data, bus_u.dout_sat, ve[t-2]);
                end
            end
            if (t < 4) begin
                bus_u.din_data = vd[t]; bus_u.din_mode = vm[t]; bus_u.din_valid = 1'b1;
            end else begin
                bus_u.din_valid = 1'b0;
            end
        end
    endtask

    task automatic test_signed();
        logic [15:0] d [27];
        logic [1:0]  m [27];
        logic [15:0] e [27];
        logic        s [27];
        int nsat = 0;
        for (int i = 0; i < 27; i++) begin
            if (i == 0) begin
                d[i] = 16'hFFE8; m[i] = 2'd1; e[i] = 16'hFFF0; s[i] = 1'b0;
            end else if (i == 1) begin
                d[i] = 16'hFFE8; m[i] = 2'd2; e[i] = 16'hFFE0; s[i] = 1'b0;
            end else if (i == 2 || i >= 23) begin
                d[i] = 16'h7FF8; m[i] = 2'd1; e[i] = 16'h7FF0; s[i] = 1'b1;
            end else begin
                d[i] = 16'($urandom_range(0, 65535));
                m[i] = 2'($urandom_range(0, 3));
                ref_round(d[i], m[i], 1'b1, 4, e[i], s[i]);
            end
            if (s[i]) nsat++;
        end
        for (int t = 0; t < 29; t++) begin
            @(negedge clk);
            if (t >= 2) begin
                checks++;
                if (bus_s.dout_valid !== 1'b1 || bus_s.dout_data !== e[t-2] || bus_s.dout_sat !== s[t-2]) begin
                    errors++;
                    $display("FAIL signed[%0d] in=%h mode=%0d got valid=%b data=%h sat=%b exp data=%h sat=%b",
                             t - 2, d[t-2], m[t-2], bus_s.dout_valid, bus_s.dout_data, bus_s.dout_sat, e[t-2], s[t-2]);
                end
            end
            if (t == 5) begin
                checks++; if (cnt_s !== 2'd1) begin errors++; $display("FAIL signed_cnt1 got=%0d exp=1", cnt_s); end
            end
            if (t < 27) begin
                bus_s.din_data = d[t]; bus_s.din_mode = m[t]; bus_s.din_valid = 1'b1;
            end else begin
                bus_s.din_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (cnt_s !== 2'((nsat > 3) ? 3 : nsat)) begin
            errors++; $display("FAIL signed_cnt_stick got=%0d exp=%0d", cnt_s, (nsat > 3) ? 3 : nsat);
        end
    endtask

    task automatic test_sat_unsigned();
        @(negedge clk);
        bus_u.dout_ready = 1'b0;
        bus_u.din_data = 16'hFFF8; bus_u.din_mode = 2'd1; bus_u.din_valid = 1'b1;
        @(negedge clk);
        bus_u.din_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus_u.dout_valid !== 1'b1 || bus_u.dout_data !== 16'hFFF0 || bus_u.dout_sat !== 1'b1 || cnt_u !== 16'd0) begin
                errors++;
                $display("FAIL sat_hold[%0d] got valid=%b data=%h sat=%b cnt=%0d exp 1/fff0/1/0",
                         k, bus_u.dout_valid, bus_u.dout_data, bus_u.dout_sat, cnt_u);
            end
        end
        bus_u.dout_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (cnt_u !== 16'd1 || bus_u.dout_valid !== 1'b0) begin
            errors++; $display("FAIL sat_count got cnt=%0d valid=%b exp cnt=1 valid=0", cnt_u, bus_u.dout_valid);
        end
        bus_u.dout_ready = 1'b0;
        bus_u.din_data = 16'hFFF8; bus_u.din_mode = 2'd1; bus_u.din_valid = 1'b1;
        @(negedge clk);
        bus_u.din_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_u.dout_valid !== 1'b1 || bus_u.dout_sat !== 1'b1) begin
            errors++; $display("FAIL sat_second got valid=%b sat=%b exp 1/1", bus_u.dout_valid, bus_u.dout_sat);
        end
        bus_u.dout_ready = 1'b1;
        clr_u = 1'b1;
        @(negedge clk);
        clr_u = 1'b0;
        checks++;
        if (cnt_u !== 16'd0 || bus_u.dout_valid !== 1'b0) begin
            errors++; $display("FAIL sat_clr_wins got cnt=%0d valid=%b exp cnt=0 valid=0", cnt_u, bus_u.dout_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] v [4];
        int idx = 0;
        int got = 0;
        v = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus_u.dout_ready = 1'b0;
            if (c >= 2) begin
                checks++;
                if (bus_u.dout_valid !== 1'b1 || bus_u.dout_data !== 16'h0010) begin
                    errors++; $display("FAIL bp_stable[%0d] got valid=%b data=%h exp 1/0010", c, bus_u.dout_valid, bus_u.dout_data);
                end
            end
            bus_u.din_valid = (idx < 4); bus_u.din_data = v[(idx < 4) ? idx : 3]; bus_u.din_mode = 2'd0;
            #2;
            if (bus_u.din_valid && bus_u.din_ready) idx++;
        end
        checks++; if (idx != 2) begin errors++; $display("FAIL bp_accepts got=%0d exp=2", idx); end
        checks++; if (bus_u.din_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", bus_u.din_ready); end
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            bus_u.dout_ready = 1'b1;
            bus_u.din_valid = (idx < 4); bus_u.din_data = v[(idx < 4) ? idx : 3];
            #2;
            if (bus_u.dout_valid) begin
                checks++;
                if (got >= 4 || bus_u.dout_data !== v[got]) begin
                    errors++; $display("FAIL bp_order[%0d] got=%h exp=%h", got, bus_u.dout_data, v[(got < 4) ? got : 3]);
                end
                got++;
            end
            if (bus_u.din_valid && bus_u.din_ready) idx++;
        end
        @(negedge clk);
        bus_u.din_valid = 1'b0;
        checks++; if (got != 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", got); end
        checks++; if (bus_u.dout_valid !== 1'b0) begin errors++; $display("FAIL bp_extra got valid=%b exp=0", bus_u.dout_valid); end
    endtask

    task automatic test_random_stream(input int n);
        int got = 0;
        int cyc = 0;
        int nsat = 0;
        logic [16:0] held = '0;
        logic held_v = 1'b0;
        exp_q.delete();
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    logic [15:0] d;
                    logic [1:0]  m;
                    logic [15:0] e;
                    logic        s;
                    int          w;
                    d = ($urandom_range(0, 3) == 0) ? (16'hFFE0 | 16'($urandom_range(0, 31))) : 16'($urandom_range(0, 65535));
                    m = 2'($urandom_range(0, 3));
                    ref_round(d, m, 1'b0, 4, e, s);
                    if ($urandom_range(0, 3) == 0) begin
                        @(negedge clk);
                        bus_u.din_valid = 1'b0;
                    end
                    @(negedge clk);
                    bus_u.din_data = d; bus_u.din_mode = m; bus_u.din_valid = 1'b1;
                    #2;
                    w = 0;
                    while (!bus_u.din_ready && w < 1000) begin
                        @(negedge clk);
                        #2;
                        w++;
                    end
                    exp_q.push_back({s, e});
                    if (s) nsat++;
                end
                @(negedge clk);
                bus_u.din_valid = 1'b0;
            end
            begin
                while (got < n && cyc < 20 * n + 100) begin
                    @(negedge clk);
                    cyc++;
                    if (held_v) begin
                        checks++;
                        if (bus_u.dout_valid !== 1'b1 || {bus_u.dout_sat, bus_u.dout_data} !== held) begin
                            errors++; $display("FAIL rand_hold got valid=%b sat/data=%h exp %h", bus_u.dout_valid, {bus_u.dout_sat, bus_u.dout_data}, held);
                        end
                    end
                    bus_u.dout_ready = ($urandom_range(0, 2) != 0);
                    #2;
                    if (bus_u.dout_valid && bus_u.dout_ready) begin
                        logic [16:0] e;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL rand_unexpected got sat/data=%h exp none", {bus_u.dout_sat, bus_u.dout_data});
                        end else begin
                            e = exp_q.pop_front();
                            if ({bus_u.dout_sat, bus_u.dout_data} !== e) begin
                                errors++; $display("FAIL rand_data[%0d] got sat/data=%h exp %h", got, {bus_u.dout_sat, bus_u.dout_data}, e);
                            end
                        end
                        got++;
                        held_v = 1'b0;
                    end else begin
                        held_v = bus_u.dout_valid;
                        held = {bus_u.dout_sat, bus_u.dout_data};
                    end
                end
            end
        join
        @(negedge clk);
        bus_u.dout_ready = 1'b1;
        bus_u.din_valid = 1'b0;
        checks++; if (got != n) begin errors++; $display("FAIL rand_timeout got=%0d exp=%0d", got, n); end
        checks++; if (cnt_u !== 16'(nsat)) begin errors++; $display("FAIL rand_cnt got=%0d exp=%0d", cnt_u, nsat); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        clr_u = 1'b1; bus_u.dout_ready = 1'b1; bus_u.din_valid = 1'b0;
        @(negedge clk);
        clr_u = 1'b0;
        bus_u.din_data = 16'hFFF8; bus_u.din_mode = 2'd1; bus_u.din_valid = 1'b1;
        @(negedge clk);
        bus_u.din_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (cnt_u !== 16'd1) begin errors++; $display("FAIL mid_precnt got=%0d exp=1", cnt_u); end
        bus_u.dout_ready = 1'b0;
        bus_u.din_data = 16'h0030; bus_u.din_mode = 2'd0; bus_u.din_valid = 1'b1;
        @(negedge clk);
        bus_u.din_data = 16'h0040;
        @(negedge clk);
        bus_u.din_valid = 1'b0;
        checks++; if (bus_u.dout_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight got valid=%b exp=1", bus_u.dout_valid); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus_u.dout_valid !== 1'b0 || bus_u.dout_data !== 16'h0 || bus_u.dout_sat !== 1'b0 || cnt_u !== 16'd0) begin
            errors++;
            $display("FAIL mid_async got valid=%b data=%h sat=%b cnt=%0d exp 0/0000/0/0",
                     bus_u.dout_valid, bus_u.dout_data, bus_u.dout_sat, cnt_u);
        end
        @(negedge clk);
        rst = 1'b0;
        bus_u.dout_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus_u.dout_valid !== 1'b0) begin errors++; $display("FAIL mid_flushed got valid=%b exp=0", bus_u.dout_valid); end
        bus_u.din_data = 16'h0018; bus_u.din_mode = 2'd1; bus_u.din_valid = 1'b1;
        @(negedge clk);
        bus_u.din_valid = 1'b0;
        checks++; if (bus_u.dout_valid !== 1'b0) begin errors++; $display("FAIL mid_early got valid=%b exp=0", bus_u.dout_valid); end
        @(negedge clk);
        checks++;
        if (bus_u.dout_valid !== 1'b1 || bus_u.dout_data !== 16'h0020) begin
            errors++; $display("FAIL mid_first got valid=%b data=%h exp 1/0020", bus_u.dout_valid, bus_u.dout_data);
        end
        @(negedge clk);
        checks++; if (bus_u.dout_valid !== 1'b0) begin errors++; $display("FAIL mid_ghost got valid=%b exp=0", bus_u.dout_valid); end
    endtask

    task automatic test_nbits0();
        logic [15:0] d [16];
        logic [1:0]  m [16];
        logic [15:0] e [16];
        logic        s [16];
        for (int i = 0; i < 16; i++) begin
            d[i] = (i == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
            m[i] = 2'($urandom_range(0, 3));
            ref_round(d[i], m[i], 1'b0, 0, e[i], s[i]);
        end
        for (int t = 0; t < 18; t++) begin
            @(negedge clk);
            if (t >= 2) begin
                checks++;
                if (bus_z.dout_valid !== 1'b1 || bus_z.dout_data !== e[t-2] || bus_z.dout_sat !== s[t-2]) begin
                    errors++;
                    $display("FAIL nbits0[%0d] in=%h mode=%0d got valid=%b data=%h sat=%b exp data=%h sat=%b",
                             t - 2, d[t-2], m[t-2], bus_z.dout_valid, bus_z.dout_data, bus_z.dout_sat, e[t-2], s[t-2]);
                end
            end
            if (t < 16) begin
                bus_z.din_data = d[t]; bus_z.din_mode = m[t]; bus_z.din_valid = 1'b1;
            end else begin
                bus_z.din_valid = 1'b0;
            end
        end
        checks++; if (cnt_z !== 16'd0) begin errors++; $display("FAIL nbits0_cnt got=%0d exp=0", cnt_z); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned_round();
        test_back_to_back();
        test_signed();
        test_sat_unsigned();
        test_backpressure();
        test_random_stream(200);
        test_reset_midstream();
        test_nbits0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
